// File: rtl/bootrom_patch.sv
// Boot ROM with fixed contents from INIT_IMAGE plus a lockable store of
// single-word patch slots. Reads are registered with one cycle of latency.
module bootrom_patch #(
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned PATCH_SLOTS = 4,
   parameter logic [DATA_W*(2**ADDR_W)-1:0] INIT_IMAGE = '0
) (
   input  logic                                 romclk,
   input  logic                                 rst,
   input  logic                                 cs,
   input  logic                                 we,
   input  logic [ADDR_W-1:0]                    addr,
   input  logic [DATA_W-1:0]                    din,
   input  logic                                 lock,
   output logic [DATA_W-1:0]                    dout,
   output logic                                 rvalid,
   output logic                                 wr_ack,
   output logic                                 wr_err,
   output logic [$clog2(PATCH_SLOTS+1)-1:0]     slots_used,
   output logic                                 locked
);

   localparam int unsigned DEPTH = 2**ADDR_W;
   localparam int unsigned IDX_W = (PATCH_SLOTS > 1) ? $clog2(PATCH_SLOTS) : 1;
   localparam int unsigned SU_W  = $clog2(PATCH_SLOTS+1);

   logic [PATCH_SLOTS-1:0] slot_valid;
   logic [ADDR_W-1:0]      slot_tag  [PATCH_SLOTS];
   logic [DATA_W-1:0]      slot_data [PATCH_SLOTS];

   logic              hit;
   logic [IDX_W-1:0]  hit_idx;
   logic              free;
   logic [IDX_W-1:0]  free_idx;
   logic [DATA_W-1:0] rd_data;
   logic              rd_req;
   logic              wr_req;
   logic              wr_hit;
   logic              wr_alloc;

   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      rd_data  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (addr == ADDR_W'(i))
            rd_data = INIT_IMAGE[i*DATA_W +: DATA_W];
      end
      // Tags are unique by construction, so at most one slot can hit.
      for (int unsigned i = 0; i < PATCH_SLOTS; i++) begin
         if (slot_valid[i] && slot_tag[i] == addr) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
            rd_data = slot_data[i];
         end
         if (!free && !slot_valid[i]) begin
            free     = 1'b1;
            free_idx = IDX_W'(i);
         end
      end
   end

   always_comb begin
      rd_req   = cs && !we;
      wr_req   = cs && we && !locked;
      wr_hit   = wr_req && hit;
      wr_alloc = wr_req && !hit && free;
   end

   always_ff @(posedge romclk or posedge rst) begin
      if (rst) begin
         slot_valid <= '0;
         dout       <= '0;
         rvalid     <= 1'b0;
         wr_ack     <= 1'b0;
         wr_err     <= 1'b0;
         slots_used <= '0;
         locked     <= 1'b0;
      end else begin
         rvalid <= rd_req;
         wr_ack <= wr_hit || wr_alloc;
         wr_err <= cs && we && !(wr_hit || wr_alloc);
         locked <= locked || lock;
         if (rd_req)
            dout <= rd_data;
         if (wr_alloc) begin
            slot_valid[free_idx] <= 1'b1;
            slots_used           <= slots_used + SU_W'(1);
         end
      end
   end

   // Tag/data payload needs no reset; the valid bits gate every use of it.
   always_ff @(posedge romclk) begin
      if (wr_hit) begin
         slot_data[hit_idx] <= din;
      end else if (wr_alloc) begin
         slot_tag[free_idx]  <= addr;
         slot_data[free_idx] <= din;
      end
   end

endmodule
